// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect -> FAULT).
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Encoding that stops fetch unless the top is given another one.
    localparam logic [ILEN-1:0] DEFAULT_HALT_INST = 32'h0000_0000;

    // FAULT is only ever entered when FETCH_ALIGN_CHECK_EN is defined.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus between the fetch stage and its environment (instruction memory,
// decode and the redirecting back-end stages).
//
// Handshake: there is no valid/ready pair on the memory side; the memory
// returns in_inst combinationally for out_inst_addr in the same cycle.
// Towards decode, out_if_valid marks a live IF/ID entry and in_stall is the
// inverse of ready: while in_stall is high the entry is held unchanged.
// in_redirect is a single-cycle strobe qualified by in_redirect_pc.
interface inst_fetch_unit_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] out_inst_addr;
    logic [ILEN-1:0] in_inst;
    logic            in_stall;
    logic            in_redirect;
    logic [XLEN-1:0] in_redirect_pc;
    logic            out_if_valid;
    logic [ILEN-1:0] out_if_inst;
    logic [XLEN-1:0] out_if_pc;
    logic            out_halted;
    logic [31:0]     out_fetch_count;
    logic            out_fetch_fault;

    // Fetch unit side.
    modport master (
        output out_inst_addr,
        input  in_inst,
        input  in_stall,
        input  in_redirect,
        input  in_redirect_pc,
        output out_if_valid,
        output out_if_inst,
        output out_if_pc,
        output out_halted,
        output out_fetch_count,
        output out_fetch_fault
    );

    // Environment side.
    modport slave (
        input  out_inst_addr,
        output in_inst,
        output in_stall,
        output in_redirect,
        output in_redirect_pc,
        input  out_if_valid,
        input  out_if_inst,
        input  out_if_pc,
        input  out_halted,
        input  out_fetch_count,
        input  out_fetch_fault
    );

endinterface

// File: rtl/inst_fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Flush wins over load; on flush only the valid
// bit drops and the stale payload is kept (it is never consumed).
module if_id_reg
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [ILEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    output logic            if_valid,
    output logic [ILEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc
);

    // Capture the fetched word and its PC, or kill the entry on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_inst  <= '0;
            if_pc    <= '0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (load) begin
            if_valid <= 1'b1;
            if_inst  <= inst;
            if_pc    <= pc;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, the RUN/HALT/FAULT state machine and the
// delivered-instruction counter; the IF/ID register lives in if_id_reg.
// Optional feature macro: FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter logic [ILEN-1:0] HALT_INST = DEFAULT_HALT_INST,
    parameter int unsigned     PC_STEP   = 4
) (
    input  logic              in_clk,
    input  logic              in_rst,
    inst_fetch_unit_if.master bus,
    output fetch_state_t      dbg_state
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc;
    fetch_state_t    state;
    logic            halted;
    logic [31:0]     fetch_count;
    logic            is_halt_word;
    logic            redirect_take;
    logic            fetch_ok;
    logic            misaligned;
    logic            ifid_load;
    logic            ifid_flush;

    // Decode the control for this cycle from the registered state.
    always_comb begin
        is_halt_word  = (bus.in_inst == HALT_INST);
        // FAULT is sticky: nothing but reset leaves it.
        redirect_take = bus.in_redirect && (state != FAULT);
        fetch_ok      = (state == RUN) && !bus.in_redirect && !bus.in_stall;
        ifid_load     = fetch_ok && !is_halt_word;
        ifid_flush    = redirect_take || (fetch_ok && is_halt_word);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fetch_fault;

    // Any target that is not word aligned is a fetch fault.
    always_comb begin
        misaligned = |bus.in_redirect_pc[1:0];
    end

    // Sticky fault flag, set by a misaligned redirect.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            fetch_fault <= 1'b0;
        end else if (redirect_take && misaligned) begin
            fetch_fault <= 1'b1;
        end
    end

    assign bus.out_fetch_fault = fetch_fault;
`else
    // Without the check misaligned targets are fetched as-is.
    always_comb begin
        misaligned = 1'b0;
    end

    assign bus.out_fetch_fault = 1'b0;
`endif

    // PC, state machine, halted flag and delivery counter.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pc          <= RESET_PC;
            state       <= RUN;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_take) begin
            pc     <= bus.in_redirect_pc;
            halted <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            state  <= misaligned ? FAULT : RUN;
`else
            state  <= RUN;
`endif
        end else if (fetch_ok) begin
            if (is_halt_word) begin
                // The halt word is swallowed; PC stays on it.
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                pc          <= pc + STEP;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (in_clk),
        .rst      (in_rst),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .inst     (bus.in_inst),
        .pc       (pc),
        .if_valid (bus.out_if_valid),
        .if_inst  (bus.out_if_inst),
        .if_pc    (bus.out_if_pc)
    );

    assign bus.out_inst_addr   = pc;
    assign bus.out_halted      = halted;
    assign bus.out_fetch_count = fetch_count;
    assign dbg_state           = state;

endmodule
